// File: rtl/matriz_carregador_pkg.sv
// matriz_carregador_pkg: shared FSM encoding, constants and packed-matrix index helper
package matriz_carregador_pkg;
  typedef enum logic [1:0] {OCIOSO, CARREGANDO, COMPLETA} estado_t;
  localparam int N_MAX = 5;
  localparam int LARGURA = 8;
  localparam int TAM_MIN = 2;
  function automatic int indice(input int i, input int j, input int n_max = N_MAX, input int largura = LARGURA);
    return (n_max * i + j) * largura;
  endfunction
endpackage

// File: rtl/matriz_carregador_contador.sv
// contador_linha_coluna: row-major (i,j) counter that saturates on the last element of an n x n matrix
module contador_linha_coluna #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         enable,
  input  logic [7:0]   n,
  output logic [W-1:0] i,
  output logic [W-1:0] j,
  output logic         ultimo
);
  logic fim_linha;
  assign fim_linha = 8'(j) == n - 8'd1;
  assign ultimo = fim_linha && 8'(i) == n - 8'd1;
  always_ff @(posedge clock) begin
    if (clear) begin
      i <= '0;
      j <= '0;
    end else if (enable && !ultimo) begin
      j <= fim_linha ? '0 : j + W'(1);
      i <= fim_linha ? i + W'(1) : i;
    end
  end
endmodule

// File: rtl/matriz_carregador.sv
// matriz_carregador: loads an n x n signed matrix element by element for the determinant stage
module matriz_carregador #(
  parameter int N_MAX = matriz_carregador_pkg::N_MAX,
  parameter int LARGURA = matriz_carregador_pkg::LARGURA
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             inicio,
  input  logic [7:0]                       tamanho_in,
  input  logic signed [LARGURA-1:0]        dado_in,
  input  logic                             dado_valido,
  output logic                             dado_pronto,
  output logic [N_MAX*N_MAX*LARGURA-1:0]   matriz,
  output logic [7:0]                       tamanho,
  output logic                             matriz_valida,
  input  logic                             matriz_ack,
  output logic                             erro
);
  import matriz_carregador_pkg::*;
  localparam int W = $clog2(N_MAX);
  estado_t estado, proximo;
  logic [W-1:0] i, j;
  logic ultimo, legal, partida, transferencia;
  assign legal = tamanho_in >= 8'(TAM_MIN) && tamanho_in <= 8'(N_MAX);
  assign partida = estado == OCIOSO && inicio && legal;
  assign dado_pronto = estado == CARREGANDO;
  assign transferencia = dado_valido && dado_pronto;
  assign matriz_valida = estado == COMPLETA;
  contador_linha_coluna #(.W(W)) u_contador (
    .clock  (clock),
    .clear  (reset || partida),
    .enable (transferencia),
    .n      (tamanho),
    .i      (i),
    .j      (j),
    .ultimo (ultimo)
  );
  always_ff @(posedge clock) estado <= reset ? OCIOSO : proximo;
  always_comb begin
    proximo = estado;
    proximo = partida ? CARREGANDO
            : (transferencia && ultimo) ? COMPLETA
            : (estado == COMPLETA && matriz_ack) ? OCIOSO
            : estado;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      matriz <= '0;
      tamanho <= '0;
      erro <= 1'b0;
    end else if (estado == OCIOSO && inicio) begin
      erro <= !legal;
      if (legal) begin
        matriz <= '0;
        tamanho <= tamanho_in;
      end
    end else if (transferencia) begin
      matriz[indice(int'(i), int'(j), N_MAX, LARGURA) +: LARGURA] <= dado_in;
    end
  end
endmodule

// File: tb/tb_matriz_carregador.sv
// tb_matriz_carregador: scoreboard bench for the matrix loader
module tb_matriz_carregador;
  logic clock = 0, reset = 1, inicio = 0, dado_valido = 0, matriz_ack = 0;
  logic [7:0] tamanho_in = 0;
  logic signed [7:0] dado_in = 0;
  logic dado_pronto, matriz_valida, erro;
  logic [199:0] matriz, snap;
  logic [7:0] tamanho;
  int comparados = 0, falhas = 0;
  typedef struct {int pos; logic [7:0] val;} item_t;
  item_t sb[$];
  item_t e;
  matriz_carregador dut (
    .clock(clock), .reset(reset), .inicio(inicio), .tamanho_in(tamanho_in),
    .dado_in(dado_in), .dado_valido(dado_valido), .dado_pronto(dado_pronto),
    .matriz(matriz), .tamanho(tamanho), .matriz_valida(matriz_valida),
    .matriz_ack(matriz_ack), .erro(erro)
  );
  always #5 clock = ~clock;
  task automatic iniciar(input int n);
    inicio = 1;
    tamanho_in = 8'(n);
    @(negedge clock);
    inicio = 0;
  endtask
  task automatic carregar(input int n, input int v0, input int passo, input bit gaps, input int quantos);
    for (int k = 0; k < quantos; k++) begin
      if (gaps) begin
        dado_valido = 0;
        dado_in = 8'h55;
        @(negedge clock);
      end
      dado_valido = 1;
      dado_in = 8'(v0 + k * passo);
      sb.push_back('{5 * (k / n) + k % n, 8'(v0 + k * passo)});
      @(negedge clock);
    end
    dado_valido = 0;
  endtask
  task automatic confirmar();
    matriz_ack = 1;
    @(negedge clock);
    matriz_ack = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clock);
    comparados += 5;
    if (matriz !== '0) begin falhas++; $display("FAIL reset matriz: got %h expected 0", matriz); end
    if (tamanho !== 8'd0) begin falhas++; $display("FAIL reset tamanho: got %0d expected 0", tamanho); end
    if (matriz_valida !== 1'b0) begin falhas++; $display("FAIL reset matriz_valida: got %b expected 0", matriz_valida); end
    if (dado_pronto !== 1'b0) begin falhas++; $display("FAIL reset dado_pronto: got %b expected 0", dado_pronto); end
    if (erro !== 1'b0) begin falhas++; $display("FAIL reset erro: got %b expected 0", erro); end
    reset = 0;
  endtask
  task automatic test_ordem5();
    iniciar(5);
    comparados++;
    if (dado_pronto !== 1'b1) begin falhas++; $display("FAIL ordem5 dado_pronto: got %b expected 1", dado_pronto); end
    carregar(5, 1, 1, 0, 25);
    comparados += 3;
    if (matriz_valida !== 1'b1) begin falhas++; $display("FAIL ordem5 latencia matriz_valida: got %b expected 1", matriz_valida); end
    if (tamanho !== 8'd5) begin falhas++; $display("FAIL ordem5 tamanho: got %0d expected 5", tamanho); end
    if (matriz[199:192] !== 8'd25) begin falhas++; $display("FAIL ordem5 elem44: got %h expected 19", matriz[199:192]); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      comparados++;
      if (matriz[e.pos*8 +: 8] !== e.val) begin falhas++; $display("FAIL ordem5 pos %0d: got %h expected %h", e.pos, matriz[e.pos*8 +: 8], e.val); end
    end
    confirmar();
    comparados++;
    if (matriz_valida !== 1'b0) begin falhas++; $display("FAIL ordem5 ack: got %b expected 0", matriz_valida); end
  endtask
  task automatic test_lacunas3();
    iniciar(3);
    carregar(3, -1, -1, 1, 9);
    comparados += 3;
    if (matriz_valida !== 1'b1) begin falhas++; $display("FAIL lacunas3 matriz_valida: got %b expected 1", matriz_valida); end
    if (matriz[103:96] !== 8'hF7) begin falhas++; $display("FAIL lacunas3 elem22: got %h expected f7", matriz[103:96]); end
    if (tamanho !== 8'd3) begin falhas++; $display("FAIL lacunas3 tamanho: got %0d expected 3", tamanho); end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (r >= 3 || c >= 3) begin
          comparados++;
          if (matriz[(5*r+c)*8 +: 8] !== 8'd0) begin falhas++; $display("FAIL lacunas3 zero (%0d,%0d): got %h expected 0", r, c, matriz[(5*r+c)*8 +: 8]); end
        end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      comparados++;
      if (matriz[e.pos*8 +: 8] !== e.val) begin falhas++; $display("FAIL lacunas3 pos %0d: got %h expected %h", e.pos, matriz[e.pos*8 +: 8], e.val); end
    end
    confirmar();
  endtask
  task automatic test_ilegal();
    int ruins[4] = '{0, 1, 6, 255};
    snap = matriz;
    foreach (ruins[k]) begin
      iniciar(ruins[k]);
      comparados += 4;
      if (erro !== 1'b1) begin falhas++; $display("FAIL ilegal erro n=%0d: got %b expected 1", ruins[k], erro); end
      if (dado_pronto !== 1'b0) begin falhas++; $display("FAIL ilegal dado_pronto n=%0d: got %b expected 0", ruins[k], dado_pronto); end
      if (matriz !== snap) begin falhas++; $display("FAIL ilegal matriz n=%0d: got %h expected %h", ruins[k], matriz, snap); end
      if (tamanho !== 8'd3) begin falhas++; $display("FAIL ilegal tamanho n=%0d: got %0d expected 3", ruins[k], tamanho); end
    end
    iniciar(2);
    comparados += 2;
    if (erro !== 1'b0) begin falhas++; $display("FAIL ilegal limpa erro: got %b expected 0", erro); end
    if (dado_pronto !== 1'b1) begin falhas++; $display("FAIL ilegal retomada dado_pronto: got %b expected 1", dado_pronto); end
    carregar(2, 10, 5, 0, 4);
    comparados++;
    if (matriz_valida !== 1'b1) begin falhas++; $display("FAIL ilegal ordem2 matriz_valida: got %b expected 1", matriz_valida); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      comparados++;
      if (matriz[e.pos*8 +: 8] !== e.val) begin falhas++; $display("FAIL ordem2 pos %0d: got %h expected %h", e.pos, matriz[e.pos*8 +: 8], e.val); end
    end
    confirmar();
  endtask
  task automatic test_reset_carga();
    iniciar(5);
    carregar(5, 1, 1, 0, 10);
    sb.delete();
    reset = 1;
    @(negedge clock);
    comparados += 5;
    if (matriz !== '0) begin falhas++; $display("FAIL reset_carga matriz: got %h expected 0", matriz); end
    if (tamanho !== 8'd0) begin falhas++; $display("FAIL reset_carga tamanho: got %0d expected 0", tamanho); end
    if (matriz_valida !== 1'b0) begin falhas++; $display("FAIL reset_carga matriz_valida: got %b expected 0", matriz_valida); end
    if (dado_pronto !== 1'b0) begin falhas++; $display("FAIL reset_carga dado_pronto: got %b expected 0", dado_pronto); end
    if (erro !== 1'b0) begin falhas++; $display("FAIL reset_carga erro: got %b expected 0", erro); end
    reset = 0;
    iniciar(5);
    carregar(5, 100, -3, 0, 25);
    comparados++;
    if (matriz_valida !== 1'b1) begin falhas++; $display("FAIL reset_carga nova matriz_valida: got %b expected 1", matriz_valida); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      comparados++;
      if (matriz[e.pos*8 +: 8] !== e.val) begin falhas++; $display("FAIL reset_carga pos %0d: got %h expected %h", e.pos, matriz[e.pos*8 +: 8], e.val); end
    end
    confirmar();
  endtask
  task automatic test_retencao_ack();
    iniciar(4);
    carregar(4, 7, 9, 0, 16);
    snap = matriz;
    for (int k = 0; k < 20; k++) begin
      dado_valido = 1;
      dado_in = 8'($urandom);
      inicio = 1;
      tamanho_in = 8'd2;
      @(negedge clock);
      comparados += 3;
      if (matriz !== snap) begin falhas++; $display("FAIL retencao matriz ciclo %0d: got %h expected %h", k, matriz, snap); end
      if (matriz_valida !== 1'b1) begin falhas++; $display("FAIL retencao matriz_valida ciclo %0d: got %b expected 1", k, matriz_valida); end
      if (tamanho !== 8'd4) begin falhas++; $display("FAIL retencao tamanho ciclo %0d: got %0d expected 4", k, tamanho); end
    end
    dado_valido = 0;
    inicio = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      comparados++;
      if (matriz[e.pos*8 +: 8] !== e.val) begin falhas++; $display("FAIL retencao pos %0d: got %h expected %h", e.pos, matriz[e.pos*8 +: 8], e.val); end
    end
    confirmar();
    comparados++;
    if (matriz_valida !== 1'b0) begin falhas++; $display("FAIL retencao ack: got %b expected 0", matriz_valida); end
  endtask
  task automatic test_back_to_back();
    iniciar(2);
    carregar(2, -50, 33, 0, 4);
    sb.delete();
    matriz_ack = 1;
    inicio = 1;
    tamanho_in = 8'd3;
    @(negedge clock);
    matriz_ack = 0;
    comparados += 3;
    if (matriz_valida !== 1'b0) begin falhas++; $display("FAIL b2b matriz_valida: got %b expected 0", matriz_valida); end
    if (dado_pronto !== 1'b0) begin falhas++; $display("FAIL b2b inicio ignorado: got %b expected 0", dado_pronto); end
    if (tamanho !== 8'd2) begin falhas++; $display("FAIL b2b tamanho: got %0d expected 2", tamanho); end
    @(negedge clock);
    inicio = 0;
    comparados += 2;
    if (dado_pronto !== 1'b1) begin falhas++; $display("FAIL b2b novo inicio: got %b expected 1", dado_pronto); end
    if (tamanho !== 8'd3) begin falhas++; $display("FAIL b2b novo tamanho: got %0d expected 3", tamanho); end
    carregar(3, 60, 7, 0, 9);
    comparados++;
    if (matriz_valida !== 1'b1) begin falhas++; $display("FAIL b2b carga matriz_valida: got %b expected 1", matriz_valida); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      comparados++;
      if (matriz[e.pos*8 +: 8] !== e.val) begin falhas++; $display("FAIL b2b pos %0d: got %h expected %h", e.pos, matriz[e.pos*8 +: 8], e.val); end
    end
    confirmar();
  endtask
  initial begin
    @(negedge clock);
    test_reset();
    test_ordem5();
    test_lacunas3();
    test_ilegal();
    test_reset_carga();
    test_retencao_ack();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, falhas);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
